// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver (2-flop sync, mid-bit sampling) feeding a show-ahead byte FIFO; push lands 9.5 bit times after start detect.
// No backpressure on the line: a push into a full FIFO without a same-cycle pop is dropped and flagged in sticky overrun.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH_LOG2   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       uart_rdreq,
  output logic [7:0] uart_in,
  output logic       uart_empty,
  output logic       overrun,
  output logic       frame_err,
  input  logic       err_clr
);

  localparam int TW    = $clog2(CLKS_PER_BIT);
  localparam int PW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [TW-1:0] TICK_MID = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TICK_END = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  logic          rx_m;
  logic          rx_s;
  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tick;
  logic [2:0]    bitcnt;
  logic [7:0]    shift;

  logic          tick_mid;
  logic          tick_end;
  logic          tick_clr;
  logic          bit_start;
  logic          shift_en;
  logic          push_req;
  logic          ferr_set;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          pop;
  logic          push_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  assign tick_mid = (tick == TICK_MID);
  assign tick_end = (tick == TICK_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (tick_mid) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (tick_end && bitcnt == 3'd7) state_nxt = STOP;
      STOP:      if (tick_end) state_nxt = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tick_clr  = 1'b0;
    bit_start = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    case (state)
      IDLE:      tick_clr = 1'b1;
      START: begin
        tick_clr  = tick_mid;
        bit_start = tick_mid && !rx_s;
      end
      DATA: begin
        tick_clr = tick_end;
        shift_en = tick_end;
      end
      STOP: begin
        tick_clr = tick_end;
        push_req = tick_end && rx_s;
        ferr_set = tick_end && !rx_s;
      end
      WAIT_IDLE: tick_clr = 1'b1;
      default:   tick_clr = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick   <= '0;
      bitcnt <= '0;
      shift  <= '0;
    end else begin
      tick <= tick_clr ? '0 : tick + TW'(1);
      if (bit_start) begin
        bitcnt <= '0;
      end else if (shift_en) begin
        bitcnt         <= bitcnt + 3'd1;
        shift[bitcnt]  <= rx_s;
      end
    end
  end

  // Wrap bit distinguishes full from empty when the index bits match.
  assign uart_empty = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]) &&
                      (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]);
  assign pop        = uart_rdreq && !uart_empty;
  assign push_ok    = push_req && (!full || pop);
  assign uart_in    = mem[rd_ptr[DEPTH_LOG2-1:0]];

  // Storage is reset so the show-ahead output never exposes X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr[DEPTH_LOG2-1:0]] <= shift;
        wr_ptr                      <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else if (err_clr) begin
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_req && !push_ok) overrun <= 1'b1;
      if (ferr_set) frame_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 16 clocks/bit, depth 4.
// Received bytes are checked against a scoreboard queue filled as frames are sent.
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int DL2 = 2;
  // rx fall -> 2 sync edges -> half bit -> 9 bits -> push edge
  localparam int PUSH_EDGE = 2 + CPB / 2 + 9 * CPB + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       uart_rdreq;
  logic [7:0] uart_in;
  logic       uart_empty;
  logic       overrun;
  logic       frame_err;
  logic       err_clr;

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] sb[$];

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH_LOG2(DL2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .uart_rdreq (uart_rdreq),
    .uart_in    (uart_in),
    .uart_empty (uart_empty),
    .overrun    (overrun),
    .frame_err  (frame_err),
    .err_clr    (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input logic stop_bit);
    rx = 1'b0;
    repeat (CPB) step();
    for (int k = 0; k < 8; k++) begin
      rx = d[k];
      repeat (CPB) step();
    end
    rx = stop_bit;
    repeat (CPB) step();
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s: observed pop request, expected scoreboard entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_empty"}, {31'd0, uart_empty}, 32'd0);
      check(tag, {24'd0, uart_in}, {24'd0, e});
    end
    uart_rdreq = 1'b1;
    step();
    uart_rdreq = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    rx         = 1'b1;
    uart_rdreq = 1'b0;
    err_clr    = 1'b0;
    repeat (3) step();
    check("rst_empty", {31'd0, uart_empty}, 32'd1);
    check("rst_uart_in", {24'd0, uart_in}, 32'h00);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // 1: single byte, exact push timing, single pop
    sb.push_back(8'hA5);
    fork
      send_bits(8'hA5, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) step();
        check("t1_empty_before_push", {31'd0, uart_empty}, 32'd1);
        step();
        check("t1_empty_after_push", {31'd0, uart_empty}, 32'd0);
      end
    join
    check("t1_overrun", {31'd0, overrun}, 32'd0);
    check("t1_frame_err", {31'd0, frame_err}, 32'd0);
    pop_check("t1_pop");
    check("t1_empty_after_pop", {31'd0, uart_empty}, 32'd1);

    // 2: overflow by one, drain in order, clear overrun
    for (int b = 1; b <= 4; b++) begin
      sb.push_back(8'(b));
      send_bits(8'(b), 1'b1);
    end
    check("t2_overrun_at_full", {31'd0, overrun}, 32'd0);
    send_bits(8'h05, 1'b1);
    check("t2_overrun_set", {31'd0, overrun}, 32'd1);
    for (int b = 0; b < 4; b++) pop_check("t2_pop");
    check("t2_empty", {31'd0, uart_empty}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t2_overrun_clr", {31'd0, overrun}, 32'd0);

    // 3: start glitch rejected; pop while empty ignored
    rx = 1'b0;
    repeat (5) step();
    rx = 1'b1;
    repeat (40) step();
    check("t3_glitch_no_push", {31'd0, uart_empty}, 32'd1);
    uart_rdreq = 1'b1;
    step();
    uart_rdreq = 1'b0;
    check("t3_empty_pop_ignored", {31'd0, uart_empty}, 32'd1);
    sb.push_back(8'h3C);
    send_bits(8'h3C, 1'b1);
    pop_check("t3_pop");
    check("t3_empty", {31'd0, uart_empty}, 32'd1);

    // 4: framing error followed by a held break
    send_bits(8'hFF, 1'b0);
    repeat (40) step();
    check("t4_frame_err", {31'd0, frame_err}, 32'd1);
    check("t4_no_push", {31'd0, uart_empty}, 32'd1);
    rx = 1'b1;
    repeat (4) step();
    sb.push_back(8'h5A);
    send_bits(8'h5A, 1'b1);
    pop_check("t4_pop");
    check("t4_frame_err_sticky", {31'd0, frame_err}, 32'd1);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("t4_frame_err_clr", {31'd0, frame_err}, 32'd0);

    // 5: pop coincides with push into a full FIFO
    for (int b = 1; b <= 4; b++) begin
      sb.push_back(8'(b * 16));
      send_bits(8'(b * 16), 1'b1);
    end
    sb.push_back(8'h77);
    fork
      send_bits(8'h77, 1'b1);
      begin
        repeat (PUSH_EDGE - 1) step();
        pop_check("t5_pop_at_push");
      end
    join
    check("t5_no_overrun", {31'd0, overrun}, 32'd0);
    for (int b = 0; b < 4; b++) pop_check("t5_drain");
    check("t5_empty", {31'd0, uart_empty}, 32'd1);

    // 6: reset mid-character with bytes buffered
    send_bits(8'hAA, 1'b1);
    send_bits(8'h55, 1'b1);
    check("t6_buffered", {31'd0, uart_empty}, 32'd0);
    sb.delete();
    fork
      send_bits(8'h99, 1'b1);
      begin
        repeat (4 * CPB + CPB / 2) step();
        rst_n = 1'b0;
        #1;
        check("t6_rst_empty", {31'd0, uart_empty}, 32'd1);
        check("t6_rst_uart_in", {24'd0, uart_in}, 32'h00);
      end
    join
    step();
    rst_n = 1'b1;
    repeat (3) step();
    sb.push_back(8'hC3);
    send_bits(8'hC3, 1'b1);
    pop_check("t6_pop");
    check("t6_empty", {31'd0, uart_empty}, 32'd1);
    check("t6_overrun", {31'd0, overrun}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
